pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 18 +
 rtl/hazard_match.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: default field widths and operand forward-select encodings.
// Also used by the core datapath muxes so both sides agree on the select codes.
package pipe_pkg;
  localparam int REG_W_DEF = 6;
  localparam int LAT_W_DEF = 3;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;
  localparam logic [1:0] FWD_D_M = 2'b01;

  // E-operand select: the younger (M) result wins over the older (W) one.
  function automatic logic [1:0] fwd_sel(input logic m_hit, input logic w_hit);
    if (m_hit) return FWD_M;
    if (w_hit) return FWD_W;
    return FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_match.sv
// Compares one source register against one stage's destination record.
// Register 0 never matches when ZERO_REG is set, since it is hard-wired to zero.
import pipe_pkg::*;

module hazard_match #(
  parameter int REG_W    = REG_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic [REG_W-1:0] i_src,
  input  logic             i_use,
  input  logic             i_wr,
  input  logic [REG_W-1:0] i_rd,
  output logic             o_match
);
  logic w_zero;

  assign w_zero  = (ZERO_REG != 0) && (i_rd == '0);
  assign o_match = i_use && i_wr && (i_src == i_rd) && !w_zero;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: tracks E/M/W destination records, detects load-use,
// branch, input-wait and multi-cycle execute stalls, and selects operand forwards.
import pipe_pkg::*;

module pipe_hazard_ctrl #(
  parameter int REG_W    = REG_W_DEF,
  parameter int LAT_W    = LAT_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             d_valid,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic             d_rs_use,
  input  logic             d_rt_use,
  input  logic             d_br,
  input  logic             d_wr,
  input  logic [REG_W-1:0] d_rd,
  input  logic             d_load,
  input  logic [LAT_W-1:0] d_lat,
  input  logic             d_in,
  input  logic             rx_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             flush_e,
  output logic             flush_m,
  output logic [1:0]       fwd_a_d,
  output logic [1:0]       fwd_b_d,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic [31:0]      stall_cnt
);
  // E also keeps its own source fields so E-operand forwards follow the instruction in E.
  logic             r_e_wr, r_e_load, r_e_rs_use, r_e_rt_use;
  logic [REG_W-1:0] r_e_rd, r_e_rs, r_e_rt;
  logic             r_m_wr, r_m_load;
  logic [REG_W-1:0] r_m_rd;
  logic             r_w_wr;
  logic [REG_W-1:0] r_w_rd;
  logic [LAT_W-1:0] r_ecnt;
  logic [31:0]      r_stall_cnt;

  logic w_rs_e, w_rt_e, w_rs_m, w_rt_m;
  logic w_ers_m, w_ert_m, w_ers_w, w_ert_w;
  logic w_mc, w_load_use, w_br_hz, w_in_wait, w_d_hz;

  hazard_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_rs_e (
    .i_src(d_rs), .i_use(d_rs_use), .i_wr(r_e_wr), .i_rd(r_e_rd), .o_match(w_rs_e));
  hazard_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_rt_e (
    .i_src(d_rt), .i_use(d_rt_use), .i_wr(r_e_wr), .i_rd(r_e_rd), .o_match(w_rt_e));
  hazard_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_rs_m (
    .i_src(d_rs), .i_use(d_rs_use), .i_wr(r_m_wr), .i_rd(r_m_rd), .o_match(w_rs_m));
  hazard_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_rt_m (
    .i_src(d_rt), .i_use(d_rt_use), .i_wr(r_m_wr), .i_rd(r_m_rd), .o_match(w_rt_m));
  hazard_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_ers_m (
    .i_src(r_e_rs), .i_use(r_e_rs_use), .i_wr(r_m_wr), .i_rd(r_m_rd), .o_match(w_ers_m));
  hazard_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_ert_m (
    .i_src(r_e_rt), .i_use(r_e_rt_use), .i_wr(r_m_wr), .i_rd(r_m_rd), .o_match(w_ert_m));
  hazard_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_ers_w (
    .i_src(r_e_rs), .i_use(r_e_rs_use), .i_wr(r_w_wr), .i_rd(r_w_rd), .o_match(w_ers_w));
  hazard_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_ert_w (
    .i_src(r_e_rt), .i_use(r_e_rt_use), .i_wr(r_w_wr), .i_rd(r_w_rd), .o_match(w_ert_w));

  always_comb begin
    w_mc       = (r_ecnt != '0);
    w_load_use = (w_rs_e || w_rt_e) && r_e_load;
    w_br_hz    = d_br && ((w_rs_e || w_rt_e) || ((w_rs_m || w_rt_m) && r_m_load));
    w_in_wait  = d_valid && d_in && !rx_ready;
    w_d_hz     = w_load_use || w_br_hz || w_in_wait;

    // A multi-cycle hold already freezes D, so it must not also bubble E.
    stall_e = w_mc;
    stall_d = w_mc || w_d_hz;
    stall_f = w_mc || w_d_hz;
    flush_e = w_d_hz && !w_mc;
    flush_m = w_mc;

    fwd_a_d = (d_br && w_rs_m && !r_m_load) ? FWD_D_M : FWD_RF;
    fwd_b_d = (d_br && w_rt_m && !r_m_load) ? FWD_D_M : FWD_RF;
    fwd_a_e = fwd_sel(w_ers_m, w_ers_w);
    fwd_b_e = fwd_sel(w_ert_m, w_ert_w);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_e_wr <= 1'b0; r_e_load <= 1'b0; r_e_rd <= '0;
      r_e_rs <= '0; r_e_rt <= '0; r_e_rs_use <= 1'b0; r_e_rt_use <= 1'b0;
      r_m_wr <= 1'b0; r_m_load <= 1'b0; r_m_rd <= '0;
      r_w_wr <= 1'b0; r_w_rd <= '0;
      r_ecnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_w_wr <= r_m_wr;
      r_w_rd <= r_m_rd;
      if (w_mc) begin
        r_m_wr   <= 1'b0;
        r_m_load <= 1'b0;
        r_m_rd   <= '0;
        r_ecnt   <= r_ecnt - LAT_W'(1);
      end else begin
        r_m_wr   <= r_e_wr;
        r_m_load <= r_e_load;
        r_m_rd   <= r_e_rd;
        if (flush_e || !d_valid) begin
          r_e_wr <= 1'b0; r_e_load <= 1'b0; r_e_rd <= '0;
          r_e_rs <= '0; r_e_rt <= '0; r_e_rs_use <= 1'b0; r_e_rt_use <= 1'b0;
          r_ecnt <= '0;
        end else begin
          r_e_wr <= d_wr; r_e_load <= d_load; r_e_rd <= d_rd;
          r_e_rs <= d_rs; r_e_rt <= d_rt; r_e_rs_use <= d_rs_use; r_e_rt_use <= d_rt_use;
          r_ecnt <= (d_lat > LAT_W'(1)) ? d_lat - LAT_W'(1) : '0;
        end
      end
      if (stall_d && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: cycle vectors with expected outputs, compared through a scoreboard,
// plus a hand-written saturation sequence on the stall counter.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, d_valid, d_rs_use, d_rt_use, d_br, d_wr, d_load, d_in, rx_ready;
  logic [5:0] d_rs, d_rt, d_rd;
  logic [2:0] d_lat;
  logic stall_f, stall_d, stall_e, flush_e, flush_m;
  logic [1:0] fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e;
  logic [31:0] stall_cnt;

  pipe_hazard_ctrl dut (
    .clk(clk), .rstn(rstn), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_rs_use(d_rs_use), .d_rt_use(d_rt_use), .d_br(d_br), .d_wr(d_wr), .d_rd(d_rd),
    .d_load(d_load), .d_lat(d_lat), .d_in(d_in), .rx_ready(rx_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .flush_e(flush_e),
    .flush_m(flush_m), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e),
    .fwd_b_e(fwd_b_e), .stall_cnt(stall_cnt));

  typedef struct {
    string nm;
    logic rstn, valid, rsu, rtu, br, wr, load, din, rxr;
    logic [5:0] rs, rt, rd;
    logic [2:0] lat;
    logic [4:0] st;
    logic [1:0] fad, fbd, fae, fbe;
    logic chk_cnt;
    logic [31:0] cnt;
  } vec_t;

  typedef struct {
    string nm;
    logic [4:0] st;
    logic [7:0] fw;
    logic chk_cnt;
    logic [31:0] cnt;
  } exp_t;

  localparam logic [4:0] ST_NO = 5'b00000;  // {stall_f, stall_d, stall_e, flush_e, flush_m}
  localparam logic [4:0] ST_HZ = 5'b11010;
  localparam logic [4:0] ST_MC = 5'b11101;

  vec_t tbl[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t I(logic wr, logic [5:0] rd, logic ld, logic [2:0] lat,
                             logic [5:0] rs, logic rsu, logic [5:0] rt, logic rtu, logic br);
    vec_t v;
    v.nm = ""; v.rstn = 1'b1; v.valid = 1'b1; v.din = 1'b0; v.rxr = 1'b1;
    v.wr = wr; v.rd = rd; v.load = ld; v.lat = lat;
    v.rs = rs; v.rsu = rsu; v.rt = rt; v.rtu = rtu; v.br = br;
    v.st = ST_NO; v.fad = 2'b00; v.fbd = 2'b00; v.fae = 2'b00; v.fbe = 2'b00;
    v.chk_cnt = 1'b0; v.cnt = 32'd0;
    return v;
  endfunction

  function automatic vec_t NOP();
    vec_t v;
    v = I(1'b0, 6'd0, 1'b0, 3'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
    v.valid = 1'b0;
    return v;
  endfunction

  task automatic put(string nm, vec_t v, logic [4:0] st, logic [1:0] fad, logic [1:0] fbd,
                     logic [1:0] fae, logic [1:0] fbe, logic chk, logic [31:0] cnt);
    v.nm = nm; v.st = st; v.fad = fad; v.fbd = fbd; v.fae = fae; v.fbe = fbe;
    v.chk_cnt = chk; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic nops(string nm, int n);
    for (int k = 0; k < n; k++) put(nm, NOP(), ST_NO, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'd0);
  endtask

  task automatic drive(vec_t v);
    rstn = v.rstn; d_valid = v.valid; d_rs = v.rs; d_rt = v.rt; d_rs_use = v.rsu;
    d_rt_use = v.rtu; d_br = v.br; d_wr = v.wr; d_rd = v.rd; d_load = v.load;
    d_lat = v.lat; d_in = v.din; rx_ready = v.rxr;
  endtask

  task automatic check_next();
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty got 0 entries want 1");
      return;
    end
    e = sb.pop_front();
    checks++;
    if ({stall_f, stall_d, stall_e, flush_e, flush_m} !== e.st) begin
      errors++;
      $display("FAIL %s stall/flush got %b want %b", e.nm,
               {stall_f, stall_d, stall_e, flush_e, flush_m}, e.st);
    end
    checks++;
    if ({fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e} !== e.fw) begin
      errors++;
      $display("FAIL %s fwd{ad,bd,ae,be} got %b want %b", e.nm,
               {fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e}, e.fw);
    end
    if (e.chk_cnt) begin
      checks++;
      if (stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s stall_cnt got %h want %h", e.nm, stall_cnt, e.cnt);
      end
    end
  endtask

  task automatic push_exp(string nm, logic [4:0] st, logic [7:0] fw, logic chk, logic [31:0] cnt);
    exp_t e;
    e.nm = nm; e.st = st; e.fw = fw; e.chk_cnt = chk; e.cnt = cnt;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // reset state
    put("reset_idle", NOP(), ST_NO, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 32'd0);
    // load r5, then add reading r5
    put("lu_load", I(1, 5, 1, 1, 1, 1, 2, 1, 0), ST_NO, 0, 0, 0, 0, 1'b1, 32'd0);
    put("lu_stall", I(1, 6, 0, 1, 5, 1, 2, 1, 0), ST_HZ, 0, 0, 0, 0, 1'b1, 32'd0);
    put("lu_retry", I(1, 6, 0, 1, 5, 1, 2, 1, 0), ST_NO, 0, 0, 0, 0, 1'b1, 32'd1);
    put("lu_fwd_w", NOP(), ST_NO, 0, 0, 2'b01, 0, 1'b1, 32'd1);
    nops("lu_drain", 2);
    // add r3; two consumers
    put("fw_add", I(1, 3, 0, 1, 1, 1, 2, 1, 0), ST_NO, 0, 0, 0, 0, 1'b0, 32'd0);
    put("fw_c1_d", I(1, 4, 0, 1, 3, 1, 8, 1, 0), ST_NO, 0, 0, 0, 0, 1'b0, 32'd0);
    put("fw_c1_e", I(1, 5, 0, 1, 3, 1, 9, 1, 0), ST_NO, 0, 0, 2'b10, 0, 1'b0, 32'd0);
    put("fw_c2_e", NOP(), ST_NO, 0, 0, 2'b01, 0, 1'b1, 32'd1);
    nops("fw_drain", 2);
    // M priority over W on rt
    put("pr_w1", I(1, 10, 0, 1, 1, 1, 2, 1, 0), ST_NO, 0, 0, 0, 0, 1'b0, 32'd0);
    put("pr_w2", I(1, 10, 0, 1, 11, 1, 12, 1, 0), ST_NO, 0, 0, 0, 0, 1'b0, 32'd0);
    put("pr_use", I(1, 13, 0, 1, 14, 1, 10, 1, 0), ST_NO, 0, 0, 0, 0, 1'b0, 32'd0);
    put("pr_m_wins", NOP(), ST_NO, 0, 0, 0, 2'b10, 1'b0, 32'd0);
    nops("pr_drain", 2);
    // 4-cycle FP op writing r40, consumer of r40
    put("mc_fp", I(1, 40, 0, 4, 20, 1, 21, 1, 0), ST_NO, 0, 0, 0, 0, 1'b1, 32'd1);
    for (int k = 0; k < 3; k++)
      put("mc_hold", I(1, 41, 0, 1, 40, 1, 22, 1, 0), ST_MC, 0, 0, 0, 0, 1'b1, 32'd1 + k);
    put("mc_release", I(1, 41, 0, 1, 40, 1, 22, 1, 0), ST_NO, 0, 0, 0, 0, 1'b1, 32'd4);
    put("mc_fwd_m", NOP(), ST_NO, 0, 0, 2'b10, 0, 1'b0, 32'd0);
    nops("mc_drain", 2);
    // r0 never hazards
    put("z_add_r0", I(1, 0, 0, 1, 1, 1, 2, 1, 0), ST_NO, 0, 0, 0, 0, 1'b0, 32'd0);
    put("z_beq_e", I(0, 0, 0, 1, 0, 1, 3, 1, 1), ST_NO, 0, 0, 0, 0, 1'b1, 32'd4);
    put("z_beq_m", I(0, 0, 0, 1, 0, 1, 4, 1, 1), ST_NO, 0, 0, 0, 0, 1'b0, 32'd0);
    nops("z_drain", 3);
    // add r7, beq r7
    put("br_add", I(1, 7, 0, 1, 1, 1, 2, 1, 0), ST_NO, 0, 0, 0, 0, 1'b0, 32'd0);
    put("br_stall", I(0, 0, 0, 1, 7, 1, 8, 1, 1), ST_HZ, 0, 0, 0, 0, 1'b1, 32'd4);
    put("br_fwd_d", I(0, 0, 0, 1, 7, 1, 8, 1, 1), ST_NO, 2'b01, 0, 0, 0, 1'b1, 32'd5);
    put("br_fwd_e", NOP(), ST_NO, 0, 0, 2'b01, 0, 1'b0, 32'd0);
    nops("br_drain", 2);
    // branch reading a load result sitting in M
    put("bl_load", I(1, 9, 1, 1, 1, 1, 2, 1, 0), ST_NO, 0, 0, 0, 0, 1'b0, 32'd0);
    nops("bl_gap", 1);
    put("bl_stall", I(0, 0, 0, 1, 9, 1, 9, 1, 1), ST_HZ, 0, 0, 0, 0, 1'b1, 32'd5);
    put("bl_go", I(0, 0, 0, 1, 9, 1, 9, 1, 1), ST_NO, 0, 0, 0, 0, 1'b1, 32'd6);
    nops("bl_drain", 2);
    // input wait
    for (int k = 0; k < 5; k++) begin
      v = I(1, 11, 0, 1, 0, 0, 0, 0, 0); v.din = 1'b1; v.rxr = 1'b0;
      put("in_wait", v, ST_HZ, 0, 0, 0, 0, 1'b1, 32'd6 + k);
    end
    v = I(1, 11, 0, 1, 0, 0, 0, 0, 0); v.din = 1'b1;
    put("in_ready", v, ST_NO, 0, 0, 0, 0, 1'b1, 32'd11);
    nops("in_drain", 3);
    v = NOP(); v.din = 1'b1; v.rxr = 1'b0;
    put("in_invalid", v, ST_NO, 0, 0, 0, 0, 1'b1, 32'd11);
    // reset during a 7-cycle hold
    put("rst_mc", I(1, 12, 0, 7, 1, 1, 2, 1, 0), ST_NO, 0, 0, 0, 0, 1'b1, 32'd11);
    put("rst_hold1", NOP(), ST_MC, 0, 0, 0, 0, 1'b1, 32'd11);
    v = NOP(); v.rstn = 1'b0;
    put("rst_hold2", v, ST_MC, 0, 0, 0, 0, 1'b1, 32'd12);
    put("rst_after", NOP(), ST_NO, 0, 0, 0, 0, 1'b1, 32'd0);
    // multi-cycle load with a load-use consumer: hold has priority
    put("pl_load", I(1, 14, 1, 3, 1, 1, 2, 1, 0), ST_NO, 0, 0, 0, 0, 1'b1, 32'd0);
    put("pl_mc1", I(1, 15, 0, 1, 14, 1, 0, 0, 0), ST_MC, 0, 0, 0, 0, 1'b1, 32'd0);
    put("pl_mc2", I(1, 15, 0, 1, 14, 1, 0, 0, 0), ST_MC, 0, 0, 0, 0, 1'b1, 32'd1);
    put("pl_lu", I(1, 15, 0, 1, 14, 1, 0, 0, 0), ST_HZ, 0, 0, 0, 0, 1'b1, 32'd2);
    put("pl_go", I(1, 15, 0, 1, 14, 1, 0, 0, 0), ST_NO, 0, 0, 0, 0, 1'b1, 32'd3);
    put("pl_fwd_w", NOP(), ST_NO, 0, 0, 2'b01, 0, 1'b1, 32'd3);
    nops("pl_drain", 2);

    drive(NOP());
    rstn = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      push_exp(tbl[i].nm, tbl[i].st, {tbl[i].fad, tbl[i].fbd, tbl[i].fae, tbl[i].fbe},
               tbl[i].chk_cnt, tbl[i].cnt);
      #1;
      check_next();
    end

    // stall counter saturation from a preloaded value
    @(negedge clk);
    v = NOP(); v.valid = 1'b1; v.din = 1'b1; v.rxr = 1'b0;
    drive(v);
    force dut.r_stall_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.r_stall_cnt;
    for (int k = 0; k < 3; k++) begin
      push_exp("sat", ST_HZ, 8'h00, 1'b1, (k == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
      @(negedge clk);
      #1;
      check_next();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
